// File: rtl/seq_state_monitor.sv
// seq_state_monitor: samples the control sequencer's one-hot strobes S0..S5, checks the
// S0->S1->..->S5->S0 lap and reports the state index, step/wrap pulses, lap count and a sticky fault.
module seq_state_monitor #(
  parameter int MAX_HOLD = 16,
  parameter int CYC_W    = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             CLR,
  input  logic             S0,
  input  logic             S1,
  input  logic             S2,
  input  logic             S3,
  input  logic             S4,
  input  logic             S5,
  output logic [2:0]       STATE,
  output logic             VALID,
  output logic             STEP,
  output logic             WRAP,
  output logic [CYC_W-1:0] CYCLES,
  output logic             ERR,
  output logic [1:0]       ERR_CODE
);

  // A zero MAX_HOLD would give a zero-width counter; keep one bit that never counts.
  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  localparam logic [1:0] CODE_ONEHOT = 2'd1;
  localparam logic [1:0] CODE_ORDER  = 2'd2;
  localparam logic [1:0] CODE_HOLD   = 2'd3;
  localparam logic [2:0] LAST_IDX    = 3'd5;

  typedef enum logic [1:0] {IDLE, TRACK, FAULT} fsm_e;

  typedef struct packed {
    logic [2:0]       state;
    logic             valid;
    logic             step;
    logic             wrap;
    logic [CYC_W-1:0] cycles;
    logic             err;
    logic [1:0]       code;
  } out_t;

  fsm_e              fsm_q, fsm_d;
  logic [5:0]        s_q;
  logic [HOLD_W-1:0] hold_q, hold_d;
  out_t              out_q, out_d;

  logic       onehot;
  logic [5:0] cur_oh, nxt_oh;
  logic [2:0] nxt_idx;
  logic       flt;
  logic [1:0] flt_code;

  assign onehot  = (s_q != 6'd0) && ((s_q & (s_q - 6'd1)) == 6'd0);
  assign nxt_idx = (out_q.state == LAST_IDX) ? 3'd0 : out_q.state + 3'd1;
  assign cur_oh  = 6'd1 << out_q.state;
  assign nxt_oh  = 6'd1 << nxt_idx;

  always_comb begin
    fsm_d      = fsm_q;
    hold_d     = hold_q;
    out_d      = out_q;
    out_d.step = 1'b0;
    out_d.wrap = 1'b0;
    flt        = 1'b0;
    flt_code   = 2'd0;
    if (CLR) begin
      fsm_d  = IDLE;
      hold_d = '0;
      out_d  = '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (s_q == 6'b000001) begin
            fsm_d       = TRACK;
            out_d.state = 3'd0;
            out_d.valid = 1'b1;
            hold_d      = HOLD_ONE;
          end
        end
        TRACK: begin
          // Not-one-hot is tested first so it wins over an ordering fault.
          if (!onehot) begin
            flt      = 1'b1;
            flt_code = CODE_ONEHOT;
          end else if (s_q == cur_oh) begin
            if (MAX_HOLD != 0) begin
              if (hold_q == HOLD_MAX) begin
                flt      = 1'b1;
                flt_code = CODE_HOLD;
              end else begin
                hold_d = hold_q + HOLD_ONE;
              end
            end
          end else if (s_q == nxt_oh) begin
            out_d.state = nxt_idx;
            out_d.step  = 1'b1;
            hold_d      = HOLD_ONE;
            if (out_q.state == LAST_IDX) begin
              out_d.wrap   = 1'b1;
              out_d.cycles = out_q.cycles + CYC_W'(1);
            end
          end else begin
            flt      = 1'b1;
            flt_code = CODE_ORDER;
          end
        end
        FAULT: ;
        default: fsm_d = IDLE;
      endcase
      // State and lap count stay at their last legal values once faulted.
      if (flt) begin
        fsm_d       = FAULT;
        out_d.valid = 1'b0;
        out_d.err   = 1'b1;
        out_d.code  = flt_code;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s_q    <= '0;
      fsm_q  <= IDLE;
      hold_q <= '0;
      out_q  <= '0;
    end else begin
      s_q    <= {S5, S4, S3, S2, S1, S0};
      fsm_q  <= fsm_d;
      hold_q <= hold_d;
      out_q  <= out_d;
    end
  end

  assign STATE    = out_q.state;
  assign VALID    = out_q.valid;
  assign STEP     = out_q.step;
  assign WRAP     = out_q.wrap;
  assign CYCLES   = out_q.cycles;
  assign ERR      = out_q.err;
  assign ERR_CODE = out_q.code;

endmodule

// File: tb/tb_seq_state_monitor.sv
// Bench for seq_state_monitor: directed lap table, hand-written corner sequences and
// randomized strobes checked every cycle against a lap-position reference model.
module tb_seq_state_monitor;
  localparam int MAX_HOLD = 16;
  localparam int CYC_W    = 8;

  logic             CLK = 1'b0;
  logic             RESET_N = 1'b0;
  logic             CLR = 1'b0;
  logic             S0 = 1'b0, S1 = 1'b0, S2 = 1'b0, S3 = 1'b0, S4 = 1'b0, S5 = 1'b0;
  logic [2:0]       STATE;
  logic             VALID, STEP, WRAP, ERR;
  logic [CYC_W-1:0] CYCLES;
  logic [1:0]       ERR_CODE;

  seq_state_monitor #(.MAX_HOLD(MAX_HOLD), .CYC_W(CYC_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CLR(CLR),
    .S0(S0), .S1(S1), .S2(S2), .S3(S3), .S4(S4), .S5(S5),
    .STATE(STATE), .VALID(VALID), .STEP(STEP), .WRAP(WRAP),
    .CYCLES(CYCLES), .ERR(ERR), .ERR_CODE(ERR_CODE)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_pass = 0;
  int step_cnt = 0, wrap_cnt = 0;

  // Reference model: lap position, run length of the current strobe, laps done.
  logic [5:0] m_cap;
  bit         m_trk, m_flt, m_step, m_wrap;
  int         m_idx, m_run, m_laps, m_code;

  typedef struct {
    logic [5:0] pat;
    logic [2:0] st;
    logic       vld, stp, wrp;
    logic [7:0] cyc;
  } vec_t;
  vec_t tbl[14];

  function automatic vec_t v(logic [5:0] pat, logic [2:0] st, logic vld, logic stp, logic wrp, logic [7:0] cyc);
    vec_t r;
    r.pat = pat; r.st = st; r.vld = vld; r.stp = stp; r.wrp = wrp; r.cyc = cyc;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic model_reset();
    m_cap = '0; m_trk = 0; m_flt = 0; m_step = 0; m_wrap = 0;
    m_idx = 0; m_run = 0; m_laps = 0; m_code = 0;
  endtask

  task automatic model_edge(input logic [5:0] p, input logic c);
    int pos, ones;
    m_step = 0;
    m_wrap = 0;
    ones = $countones(m_cap);
    pos = -1;
    for (int i = 0; i < 6; i++) if (m_cap[i]) pos = i;
    if (c) begin
      m_trk = 0; m_flt = 0; m_idx = 0; m_run = 0; m_laps = 0; m_code = 0;
    end else if (m_flt) begin
    end else if (!m_trk) begin
      if (m_cap == 6'b000001) begin m_trk = 1; m_idx = 0; m_run = 1; end
    end else if (ones != 1) begin
      m_flt = 1; m_code = 1;
    end else if (pos == m_idx) begin
      if (MAX_HOLD != 0 && m_run >= MAX_HOLD) begin m_flt = 1; m_code = 3; end
      else m_run++;
    end else if (pos == (m_idx + 1) % 6) begin
      m_step = 1; m_run = 1;
      if (pos == 0) begin m_wrap = 1; m_laps = (m_laps + 1) % (1 << CYC_W); end
      m_idx = pos;
    end else begin
      m_flt = 1; m_code = 2;
    end
    m_cap = p;
  endtask

  task automatic check_model();
    chk("model_state", STATE, m_idx);
    chk("model_valid", VALID, int'(m_trk && !m_flt));
    chk("model_step", STEP, m_step);
    chk("model_wrap", WRAP, m_wrap);
    chk("model_cycles", CYCLES, m_laps);
    chk("model_err", ERR, m_flt);
    chk("model_code", ERR_CODE, m_code);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_state"}, STATE, 0);
    chk({tag, "_valid"}, VALID, 0);
    chk({tag, "_step"}, STEP, 0);
    chk({tag, "_wrap"}, WRAP, 0);
    chk({tag, "_cycles"}, CYCLES, 0);
    chk({tag, "_err"}, ERR, 0);
    chk({tag, "_code"}, ERR_CODE, 0);
  endtask

  task automatic cycle(input logic [5:0] p, input logic c);
    {S5, S4, S3, S2, S1, S0} = p;
    CLR = c;
    @(posedge CLK);
    model_edge(p, c);
    #1;
    step_cnt += int'(STEP);
    wrap_cnt += int'(WRAP);
    check_model();
  endtask

  task automatic run_pat(input logic [5:0] p, input int n);
    for (int i = 0; i < n; i++) cycle(p, 1'b0);
  endtask

  task automatic lap();
    for (int i = 0; i < 6; i++) cycle(6'd1 << i, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    RESET_N = 1'b0;
    CLR = 1'b0;
    #1;
    model_reset();
    check_zero(tag);
    @(posedge CLK);
    #2;
    RESET_N = 1'b1;
    step_cnt = 0;
    wrap_cnt = 0;
  endtask

  initial begin
    logic [5:0] p;
    logic       c;
    int         r, di, len;

    tbl[0]  = v(6'b000001, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    tbl[1]  = v(6'b000010, 3'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    tbl[2]  = v(6'b000100, 3'd1, 1'b1, 1'b1, 1'b0, 8'd0);
    tbl[3]  = v(6'b001000, 3'd2, 1'b1, 1'b1, 1'b0, 8'd0);
    tbl[4]  = v(6'b010000, 3'd3, 1'b1, 1'b1, 1'b0, 8'd0);
    tbl[5]  = v(6'b100000, 3'd4, 1'b1, 1'b1, 1'b0, 8'd0);
    tbl[6]  = v(6'b000001, 3'd5, 1'b1, 1'b1, 1'b0, 8'd0);
    tbl[7]  = v(6'b000010, 3'd0, 1'b1, 1'b1, 1'b1, 8'd1);
    tbl[8]  = v(6'b000100, 3'd1, 1'b1, 1'b1, 1'b0, 8'd1);
    tbl[9]  = v(6'b001000, 3'd2, 1'b1, 1'b1, 1'b0, 8'd1);
    tbl[10] = v(6'b010000, 3'd3, 1'b1, 1'b1, 1'b0, 8'd1);
    tbl[11] = v(6'b100000, 3'd4, 1'b1, 1'b1, 1'b0, 8'd1);
    tbl[12] = v(6'b000001, 3'd5, 1'b1, 1'b1, 1'b0, 8'd1);
    tbl[13] = v(6'b000001, 3'd0, 1'b1, 1'b1, 1'b1, 8'd2);

    // Two laps, one cycle per strobe, ending on S0.
    do_reset("rst0");
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].pat, 1'b0);
      chk($sformatf("vec%0d_state", i), STATE, tbl[i].st);
      chk($sformatf("vec%0d_valid", i), VALID, tbl[i].vld);
      chk($sformatf("vec%0d_step", i), STEP, tbl[i].stp);
      chk($sformatf("vec%0d_wrap", i), WRAP, tbl[i].wrp);
      chk($sformatf("vec%0d_cycles", i), CYCLES, tbl[i].cyc);
    end
    chk("lap_err", ERR, 0);
    chk("lap_wraps", wrap_cnt, 2);
    chk("lap_steps", step_cnt, 12);

    // S2 held for exactly MAX_HOLD captured cycles is legal.
    do_reset("rst1");
    cycle(6'b000001, 1'b0);
    cycle(6'b000010, 1'b0);
    run_pat(6'b000100, MAX_HOLD);
    run_pat(6'b001000, 2);
    chk("hold16_err", ERR, 0);
    chk("hold16_state", STATE, 3);

    // One more cycle of S2 is a hold timeout.
    do_reset("rst2");
    cycle(6'b000001, 1'b0);
    cycle(6'b000010, 1'b0);
    run_pat(6'b000100, MAX_HOLD + 1);
    run_pat(6'b001000, 2);
    chk("hold17_err", ERR, 1);
    chk("hold17_code", ERR_CODE, 3);
    chk("hold17_state", STATE, 2);

    // Skipped strobe: only S0->S1 steps, the fault edge does not.
    do_reset("rst3");
    cycle(6'b000001, 1'b0);
    cycle(6'b000010, 1'b0);
    cycle(6'b001000, 1'b0);
    cycle(6'b001000, 1'b0);
    chk("skip_err", ERR, 1);
    chk("skip_code", ERR_CODE, 2);
    chk("skip_state", STATE, 1);
    chk("skip_steps", step_cnt, 1);

    // Multi-hot strobe, then a one-cycle clear.
    do_reset("rst4");
    cycle(6'b000001, 1'b0);
    cycle(6'b000011, 1'b0);
    cycle(6'b000000, 1'b0);
    chk("multi_err", ERR, 1);
    chk("multi_code", ERR_CODE, 1);
    cycle(6'b000000, 1'b1);
    chk("clr_err", ERR, 0);
    chk("clr_cycles", CYCLES, 0);
    chk("clr_valid", VALID, 0);
    chk("clr_code", ERR_CODE, 0);

    // Non-S0 strobes after reset are ignored until S0 shows up.
    do_reset("rst5");
    cycle(6'b001000, 1'b0);
    cycle(6'b010000, 1'b0);
    cycle(6'b110000, 1'b0);
    cycle(6'b000000, 1'b0);
    chk("idle_valid", VALID, 0);
    chk("idle_err", ERR, 0);
    lap();
    cycle(6'b000001, 1'b0);
    cycle(6'b000001, 1'b0);
    chk("idle_lap_cycles", CYCLES, 1);
    chk("idle_lap_valid", VALID, 1);

    // Multi-cycle clear keeps the block idle even with S0 present.
    for (int i = 0; i < 3; i++) begin
      cycle(6'b000001, 1'b1);
      chk($sformatf("clr_hold%0d_valid", i), VALID, 0);
    end
    cycle(6'b000010, 1'b0);
    chk("clr_resume_valid", VALID, 1);
    chk("clr_resume_state", STATE, 0);

    // Lap counter wraps without error.
    do_reset("rst6");
    for (int i = 0; i < (1 << CYC_W); i++) lap();
    cycle(6'b000001, 1'b0);
    cycle(6'b000001, 1'b0);
    chk("cycwrap_cycles", CYCLES, 0);
    chk("cycwrap_err", ERR, 0);
    chk("cycwrap_wraps", wrap_cnt, 1 << CYC_W);

    // Asynchronous reset mid-lap clears outputs before the next edge.
    do_reset("rst7");
    for (int i = 0; i < 3; i++) lap();
    cycle(6'b000001, 1'b0);
    cycle(6'b000010, 1'b0);
    cycle(6'b000100, 1'b0);
    chk("pre_async_cycles", CYCLES, 3);
    #2;
    RESET_N = 1'b0;
    #1;
    check_zero("async");
    do_reset("rst8");

    // Randomized strobes against the model.
    di = 0;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      c = 1'b0;
      if (r == 0) begin
        do_reset("rrst");
        di = 0;
        continue;
      end
      if (r < 3) c = 1'b1;
      if (r < 5) begin
        p = 6'($urandom);
        cycle(p, c);
      end else if (r < 8) begin
        p = 6'd1 << $urandom_range(0, 5);
        cycle(p, c);
      end else if (r < 10) begin
        len = $urandom_range(MAX_HOLD - 2, MAX_HOLD + 2);
        p = 6'd1 << di;
        run_pat(p, len);
      end else begin
        if ($urandom_range(0, 2) != 0) di = (di + 1) % 6;
        p = 6'd1 << di;
        cycle(p, c);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
